// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_ctrl_pkg                                              |
// | Brief    : Shared types and constants for the ALU command front-end  |
// |            and the ALU it drives.                                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package alu_ctrl_pkg;

    // Controller states, explicitly encoded so the 3-bit register is fixed.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_GET_B    = 3'd2,
        ST_GET_FUN  = 3'd3,
        ST_ALU_RUN  = 3'd4,
        ST_ALU_WAIT = 3'd5,
        ST_TX_LO    = 3'd6,
        ST_TX_HI    = 3'd7
    } ctrl_state_e;

    // Frame opcodes.
    localparam logic [7:0] CMD_OP_AB    = 8'hCC;
    localparam logic [7:0] CMD_OP_REUSE = 8'hDD;

    // Function code the ALU does not implement.
    localparam logic [3:0] FUN_INVALID  = 4'hF;

    // ALU function codes, shared with the ALU itself.
    localparam logic [3:0] ALU_ADD      = 4'h0;
    localparam logic [3:0] ALU_SUB      = 4'h1;
    localparam logic [3:0] ALU_MUL      = 4'h2;
    localparam logic [3:0] ALU_DIV      = 4'h3;
    localparam logic [3:0] ALU_AND      = 4'h4;
    localparam logic [3:0] ALU_OR       = 4'h5;
    localparam logic [3:0] ALU_NAND     = 4'h6;
    localparam logic [3:0] ALU_NOR      = 4'h7;
    localparam logic [3:0] ALU_XOR      = 4'h8;
    localparam logic [3:0] ALU_XNOR     = 4'h9;
    localparam logic [3:0] ALU_CMP_EQ   = 4'hA;
    localparam logic [3:0] ALU_CMP_GT   = 4'hB;
    localparam logic [3:0] ALU_CMP_LT   = 4'hC;
    localparam logic [3:0] ALU_SHIFT_R  = 4'hD;
    localparam logic [3:0] ALU_SHIFT_L  = 4'hE;

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/result_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : result_serializer                                         |
// | Brief    : Holds a 16-bit result and emits it as two bytes, low byte |
// |            first, on a valid/ready interface.                        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module result_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_result,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid
);

    logic [15:0] r_result;
    logic        r_valid;
    logic        r_hi;

    // Capture a result on load, then advance low -> high -> empty on each handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 16'h0000;
            r_valid  <= 1'b0;
            r_hi     <= 1'b0;
        end else if (i_load) begin
            r_result <= i_result;
            r_valid  <= 1'b1;
            r_hi     <= 1'b0;
        end else if (r_valid && i_tx_ready) begin
            if (r_hi) begin
                r_valid <= 1'b0;
                r_hi    <= 1'b0;
            end else begin
                r_hi    <= 1'b1;
            end
        end
    end

    // Outputs come straight from registers, so they hold while ready is low.
    assign o_tx_data  = r_hi ? r_result[15:8] : r_result[7:0];
    assign o_tx_valid = r_valid;

endmodule : result_serializer
`default_nettype wire

// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : alu_cmd_ctrl                                              |
// | Brief    : Parses byte command frames, drives the ALU, and returns   |
// |            the 16-bit result as two bytes on a valid/ready port.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    output logic [3:0]              alu_fun,
    output logic                    alu_en,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    input  logic                    alu_out_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    cmd_error
);

    localparam logic [2:0] c_timeout = 3'(TIMEOUT);

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_next;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [3:0]            r_alu_fun;
    logic [2:0]            r_cnt;
    logic [2:0]            w_cnt_inc;
    logic                  r_cmd_error;
    logic                  w_err;
    logic                  w_load_a;
    logic                  w_load_b;
    logic                  w_load_fun;
    logic                  w_capture;
    logic                  w_tx_hs;

    assign w_cnt_inc = (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;
    assign w_tx_hs   = tx_valid && tx_ready;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic and per-cycle strobes; bytes arriving while busy are flagged but never alter the flow.
    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_load_a     = 1'b0;
        w_load_b     = 1'b0;
        w_load_fun   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_OP_AB)         w_state_next = ST_GET_A;
                    else if (rx_data == CMD_OP_REUSE) w_state_next = ST_GET_FUN;
                    else                              w_err        = 1'b1;
                end
            end
            ST_GET_A: begin
                if (rx_valid) begin
                    w_load_a     = 1'b1;
                    w_state_next = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (rx_valid) begin
                    w_load_b     = 1'b1;
                    w_state_next = ST_GET_FUN;
                end
            end
            ST_GET_FUN: begin
                if (rx_valid) begin
                    if (rx_data[3:0] == FUN_INVALID) begin
                        w_err        = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_load_fun   = 1'b1;
                        w_state_next = ST_ALU_RUN;
                    end
                end
            end
            ST_ALU_RUN: begin
                w_err        = rx_valid;
                w_state_next = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: begin
                w_err = rx_valid;
                if (alu_out_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_TX_LO;
                end else if (w_cnt_inc == c_timeout) begin
                    w_err        = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            ST_TX_LO: begin
                w_err = rx_valid;
                if (w_tx_hs) w_state_next = ST_TX_HI;
            end
            ST_TX_HI: begin
                w_err = rx_valid;
                if (w_tx_hs) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand and function registers; they keep their values across frames.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= 4'h0;
        end else begin
            if (w_load_a)   r_alu_a   <= rx_data[DATA_WIDTH-1:0];
            if (w_load_b)   r_alu_b   <= rx_data[DATA_WIDTH-1:0];
            if (w_load_fun) r_alu_fun <= rx_data[3:0];
        end
    end

    // Wait counter: zeroed while the ALU is enabled, counts up and saturates while waiting.
    always_ff @(posedge CLK) begin
        if (RST)                           r_cnt <= 3'd0;
        else if (r_state == ST_ALU_RUN)    r_cnt <= 3'd0;
        else if (r_state == ST_ALU_WAIT)   r_cnt <= w_cnt_inc;
    end

    // Error pulse lands one cycle after the offending byte or timeout.
    always_ff @(posedge CLK) begin
        if (RST) r_cmd_error <= 1'b0;
        else     r_cmd_error <= w_err;
    end

    result_serializer u_result_serializer (
        .clk        (CLK),
        .rst        (RST),
        .i_load     (w_capture),
        .i_result   (alu_out),
        .i_tx_ready (tx_ready),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid)
    );

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_fun   = r_alu_fun;
    assign alu_en    = (r_state == ST_ALU_RUN);
    assign cmd_error = r_cmd_error;

endmodule : alu_cmd_ctrl
`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_alu_cmd_ctrl                                           |
// | Brief    : Scoreboard bench for alu_cmd_ctrl with a stub ALU.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_alu_cmd_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] f;
    } op_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_fun;
    logic        alu_en;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        cmd_error;
    logic        stub_dead;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_err = 0;
    int          n_en  = 0;
    logic [7:0]  exp_bytes[$];
    op_t         exp_ops[$];

    alu_cmd_ctrl #(.DATA_WIDTH(8), .TIMEOUT(4)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_fun       (alu_fun),
        .alu_en        (alu_en),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .cmd_error     (cmd_error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Stub ALU: registered result and valid one cycle after enable.
    always @(posedge CLK) begin
        if (RST) begin
            alu_out       <= 16'h0000;
            alu_out_valid <= 1'b0;
        end else begin
            alu_out_valid <= alu_en && !stub_dead;
            if (alu_en) begin
                case (alu_fun)
                    ALU_ADD: alu_out <= 16'(alu_a) + 16'(alu_b);
                    ALU_SUB: alu_out <= 16'(alu_a) - 16'(alu_b);
                    ALU_MUL: alu_out <= 16'(alu_a) * 16'(alu_b);
                    default: alu_out <= 16'h0000;
                endcase
            end
        end
    end

    // Monitor: score transmitted bytes and ALU accesses on the falling edge.
    always @(negedge CLK) begin
        if (cmd_error) n_err++;
        if (alu_en) begin
            n_en++;
            if (exp_ops.size() == 0) begin
                chk("unexpected_alu_en", 32'd1, 32'd0);
            end else begin
                op_t o;
                o = exp_ops.pop_front();
                chk("alu_a", {24'd0, alu_a}, {24'd0, o.a});
                chk("alu_b", {24'd0, alu_b}, {24'd0, o.b});
                chk("alu_fun", {28'd0, alu_fun}, {28'd0, o.f});
            end
        end
        if (tx_valid && tx_ready) begin
            if (exp_bytes.size() == 0) begin
                chk("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_bytes.pop_front();
                chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_bytes.size() == 0) break;
            @(negedge CLK);
        end
        chk("drain_bytes", exp_bytes.size(), 0);
        @(posedge CLK); #1;
    endtask

    task automatic wait_txv();
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (tx_valid) break;
        end
        chk("tx_valid_wait", {31'd0, tx_valid}, 1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_a"}, {24'd0, alu_a}, 0);
        chk({tag, "_b"}, {24'd0, alu_b}, 0);
        chk({tag, "_fun"}, {28'd0, alu_fun}, 0);
        chk({tag, "_en"}, {31'd0, alu_en}, 0);
        chk({tag, "_txv"}, {31'd0, tx_valid}, 0);
        chk({tag, "_txd"}, {24'd0, tx_data}, 0);
        chk({tag, "_err"}, {31'd0, cmd_error}, 0);
    endtask

    initial begin
        int e0;
        int n0;
        RST = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0; stub_dead = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk_zero_outputs("reset");
        @(posedge CLK); #1;
        RST = 1'b0;
        tx_ready = 1'b1;

        // ADD 5+3 with latency checks.
        exp_ops.push_back('{8'h05, 8'h03, ALU_ADD});
        exp_bytes.push_back(8'h08); exp_bytes.push_back(8'h00);
        send_byte(CMD_OP_AB); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
        @(negedge CLK);
        chk("lat_en_n1", {31'd0, alu_en}, 1);
        @(negedge CLK);
        chk("lat_en_n2", {31'd0, alu_en}, 0);
        chk("lat_txv_n2", {31'd0, tx_valid}, 0);
        @(negedge CLK);
        chk("lat_txv_n3", {31'd0, tx_valid}, 1);
        chk("lat_txd_n3", {24'd0, tx_data}, 32'h08);
        wait_drain();

        // MUL 0x10*0x10, then reuse operands with SUB.
        e0 = n_err;
        exp_ops.push_back('{8'h10, 8'h10, ALU_MUL});
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
        send_byte(CMD_OP_AB); send_byte(8'h10); send_byte(8'h10); send_byte(8'h02);
        wait_drain();
        exp_ops.push_back('{8'h10, 8'h10, ALU_SUB});
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
        send_byte(CMD_OP_REUSE); send_byte(8'hF1);
        wait_drain();
        chk("no_err_good_frames", n_err - e0, 0);

        // Invalid function code.
        e0 = n_err; n0 = n_en;
        send_byte(CMD_OP_AB); send_byte(8'h07); send_byte(8'h02); send_byte(8'h0F);
        @(negedge CLK);
        chk("badfun_err", {31'd0, cmd_error}, 1);
        @(negedge CLK);
        chk("badfun_err_end", {31'd0, cmd_error}, 0);
        repeat (3) @(negedge CLK);
        chk("badfun_err_cnt", n_err - e0, 1);
        chk("badfun_no_en", n_en - n0, 0);
        chk("badfun_no_tx", {31'd0, tx_valid}, 0);
        @(posedge CLK); #1;

        // Result 0x1234 with transmit back-pressure.
        tx_ready = 1'b0;
        exp_ops.push_back('{8'hE9, 8'h14, ALU_MUL});
        exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h12);
        send_byte(CMD_OP_AB); send_byte(8'hE9); send_byte(8'h14); send_byte(8'h02);
        wait_txv();
        for (int i = 0; i < 5; i++) begin
            chk("hold_txv", {31'd0, tx_valid}, 1);
            chk("hold_txd", {24'd0, tx_data}, 32'h34);
            @(negedge CLK);
        end
        @(posedge CLK); #1;
        tx_ready = 1'b1;
        wait_drain();

        // ALU never answers: timeout error, no transmit.
        stub_dead = 1'b1;
        e0 = n_err;
        exp_ops.push_back('{8'hE9, 8'h14, ALU_ADD});
        send_byte(CMD_OP_REUSE); send_byte(8'h00);
        @(negedge CLK);
        chk("to_en", {31'd0, alu_en}, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("to_early_err", {31'd0, cmd_error}, 0);
        end
        @(negedge CLK);
        chk("to_err", {31'd0, cmd_error}, 1);
        chk("to_no_tx", {31'd0, tx_valid}, 0);
        @(negedge CLK);
        chk("to_err_cnt", n_err - e0, 1);
        @(posedge CLK); #1;
        stub_dead = 1'b0;

        // Stray byte during TX_LO.
        tx_ready = 1'b0;
        exp_ops.push_back('{8'hE9, 8'h14, ALU_MUL});
        exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h12);
        send_byte(CMD_OP_REUSE); send_byte(8'h02);
        wait_txv();
        @(posedge CLK); #1;
        send_byte(8'h55);
        @(negedge CLK);
        chk("stray_err", {31'd0, cmd_error}, 1);
        chk("stray_txv", {31'd0, tx_valid}, 1);
        chk("stray_txd", {24'd0, tx_data}, 32'h34);
        @(posedge CLK); #1;
        tx_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a frame.
        send_byte(CMD_OP_AB); send_byte(8'h42);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk_zero_outputs("midrst");
        @(posedge CLK); #1;
        exp_ops.push_back('{8'h00, 8'h00, ALU_ADD});
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h00);
        send_byte(CMD_OP_REUSE); send_byte(8'h00);
        wait_drain();

        chk("ops_left", exp_ops.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_cmd_ctrl
`default_nettype wire
